// File: rtl/acc_core_pkg.sv
// Shared opcode, FSM-state and ALU-function definitions for the multi-cycle accumulator core.
package acc_core_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_JR  = 4'h9;
  localparam logic [3:0] OP_BRA = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_SHL = 4'hD;
  localparam logic [3:0] OP_SHR = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_e;

  typedef enum logic [2:0] {
    ALU_PASSB, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR
  } alu_func_e;

  function automatic alu_func_e op_to_func(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      default: return ALU_PASSB;
    endcase
  endfunction

endpackage

// File: rtl/acc_core_alu.sv
// Combinational ALU for the accumulator core; cout is carry, borrow or shifted-out bit by function.
module acc_core_alu
  import acc_core_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_func_e         func,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              zero
);

  logic [DATA_W:0] w_ext;

  always_comb begin
    w_ext  = '0;
    result = '0;
    cout   = 1'b0;
    case (func)
      ALU_ADD: begin
        w_ext  = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        result = w_ext[DATA_W-1:0];
        cout   = w_ext[DATA_W];
      end
      // Unsigned underflow wraps into the extra top bit, which is the borrow.
      ALU_SUB: begin
        w_ext  = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
        result = w_ext[DATA_W-1:0];
        cout   = w_ext[DATA_W];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result = a << 1;
        cout   = a[DATA_W-1];
      end
      ALU_SHR: begin
        result = a >> 1;
        cout   = a[0];
      end
      default: result = b;
    endcase
  end

  assign zero = ~|result;

endmodule

// File: rtl/acc_core_mc.sv
// Multi-cycle accumulator core: FETCH with req/ack wait states, one-cycle EXEC, sticky HALT.
module acc_core_mc
  import acc_core_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned NREG     = 16,
  parameter int unsigned OPND_W   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              CLB,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [OPND_W+3:0] imem_data,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  output logic              zf,
  output logic              cf,
  output logic              retire,
  output logic              halted
);

  localparam int unsigned RA_W = $clog2(NREG);

  state_e              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_acc;
  logic                r_zf;
  logic                r_cf;
  logic [OPND_W+3:0]   r_ir;
  logic [DATA_W-1:0]   r_regs [NREG];

  logic [3:0]          w_op;
  logic [OPND_W-1:0]   w_opnd;
  logic [RA_W-1:0]     w_ra;
  logic [DATA_W-1:0]   w_r;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_b;
  logic [PC_W-1:0]     w_off;
  logic [PC_W-1:0]     w_pc_rel;
  logic [PC_W-1:0]     w_jr;
  alu_func_e           w_func;
  logic [DATA_W-1:0]   w_res;
  logic                w_cout;
  logic                w_zero;

  assign w_op     = r_ir[OPND_W+3:OPND_W];
  assign w_opnd   = r_ir[OPND_W-1:0];
  assign w_ra     = w_opnd[RA_W-1:0];
  assign w_r      = r_regs[w_ra];
  assign w_imm    = DATA_W'(w_opnd);
  assign w_off    = PC_W'(signed'(w_opnd));
  // pc already points past the branch here, so offset -1 re-executes it.
  assign w_pc_rel = r_pc + w_off;
  assign w_jr     = PC_W'(w_r);
  assign w_b      = (w_op == OP_LDI) ? w_imm : w_r;
  assign w_func   = op_to_func(w_op);

  acc_core_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (r_acc),
    .b      (w_b),
    .func   (w_func),
    .cin    (1'b0),
    .result (w_res),
    .cout   (w_cout),
    .zero   (w_zero)
  );

  always_ff @(posedge clk) begin
    if (CLB) begin
      r_state <= ST_FETCH;
      r_pc    <= PC_W'(RESET_PC);
      r_acc   <= '0;
      r_ir    <= '0;
      r_zf    <= 1'b0;
      r_cf    <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_data;
            r_pc    <= r_pc + PC_W'(1);
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= (w_op == OP_HLT) ? ST_HALT : ST_FETCH;
          case (w_op)
            OP_LDI, OP_LDR, OP_AND, OP_OR, OP_XOR: begin
              r_acc <= w_res;
              r_zf  <= w_zero;
            end
            OP_ADD, OP_SUB, OP_SHL, OP_SHR: begin
              r_acc <= w_res;
              r_zf  <= w_zero;
              r_cf  <= w_cout;
            end
            OP_STR: r_regs[w_ra] <= r_acc;
            OP_JR:  r_pc <= w_jr;
            OP_BRA: r_pc <= w_pc_rel;
            OP_JZ:  if (r_zf) r_pc <= w_pc_rel;
            OP_JC:  if (r_cf) r_pc <= w_pc_rel;
            default: ;
          endcase
        end
        ST_HALT: ;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign imem_req  = (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign acc       = r_acc;
  assign zf        = r_zf;
  assign cf        = r_cf;
  assign retire    = (r_state == ST_EXEC);
  assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_acc_core_mc.sv
// Self-checking bench for acc_core_mc: vector table, directed corner sequences, random programs vs a model.
module tb_acc_core_mc;

  logic       clk = 1'b0;
  logic       CLB = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = '0;
  logic [7:0] pc;
  logic [7:0] acc;
  logic       zf, cf, retire, halted;

  acc_core_mc #(.DATA_W(8), .PC_W(8), .NREG(16), .OPND_W(4), .RESET_PC(0)) dut (
    .clk(clk), .CLB(CLB), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .pc(pc), .acc(acc),
    .zf(zf), .cf(cf), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int rcnt  = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (retire === 1'b1) rcnt <= rcnt + 1;
  end

  // Instruction memory responder with optional targeted and random wait states
  logic [7:0] mem [256];
  logic [7:0] stall_addr = '0;
  int         stall_left = 0;
  bit         rnd_mode   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (imem_req === 1'b1) begin
        if (imem_addr == stall_addr && stall_left > 0) stall_left--;
        else if (rnd_mode) imem_ack = ($urandom_range(0, 2) != 0);
        else imem_ack = 1'b1;
        imem_data = mem[imem_addr];
      end
    end
  end

  // Reference model: instruction-level semantics with plain integer arithmetic
  int m_pc, m_acc;
  int m_regs [16];
  bit m_zf, m_cf, m_halt;

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_zf = 0; m_cf = 0; m_halt = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
  endtask

  task automatic model_step();
    int ins, op, o, r, npc, off, s;
    ins = int'(mem[m_pc]);
    op  = ins / 16;
    o   = ins % 16;
    r   = m_regs[o];
    npc = (m_pc + 1) % 256;
    off = (o >= 8) ? o - 16 : o;
    case (op)
      1:  m_acc = o;
      2:  m_acc = r;
      3:  m_regs[o] = m_acc;
      4:  begin s = m_acc + r; m_cf = (s > 255); m_acc = s % 256; end
      5:  begin m_cf = (m_acc < r); m_acc = (m_acc - r + 256) % 256; end
      6:  m_acc = m_acc & r;
      7:  m_acc = m_acc | r;
      8:  m_acc = m_acc ^ r;
      9:  npc = r;
      10: npc = (npc + off + 256) % 256;
      11: if (m_zf) npc = (npc + off + 256) % 256;
      12: if (m_cf) npc = (npc + off + 256) % 256;
      13: begin m_cf = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
      14: begin m_cf = (m_acc % 2 == 1); m_acc = m_acc / 2; end
      15: m_halt = 1;
      default: ;
    endcase
    if (op == 1 || op == 2 || (op >= 4 && op <= 8) || op == 13 || op == 14) m_zf = (m_acc == 0);
    m_pc = npc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    CLB = 1'b1;
    @(negedge clk);
    CLB = 1'b0;
  endtask

  task automatic wait_retire(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (retire === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL retire_timeout: got no retire expected retire within 200 cycles");
    end
  endtask

  task automatic run_instr(input int n);
    bit ok;
    repeat (n) begin
      wait_retire(ok);
      if (!ok) return;
      @(negedge clk);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic branch_case(input string name, input logic [7:0] ldi, input logic [7:0] jz,
                             input logic [7:0] exp_addr);
    clear_mem();
    mem[8'h10] = ldi;
    mem[8'h11] = jz;
    do_reset();
    run_instr(18);
    check(name, {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, exp_addr});
  endtask

  typedef struct {
    logic [7:0] ins;
    logic [7:0] acc;
    logic       zf;
    logic       cf;
  } vec_t;

  vec_t tbl [9];

  initial begin
    bit   ok;
    int   cyc0, r0;
    logic bad;

    tbl[0] = '{8'h1F, 8'h0F, 1'b0, 1'b0};
    tbl[1] = '{8'hD0, 8'h1E, 1'b0, 1'b0};
    tbl[2] = '{8'hD0, 8'h3C, 1'b0, 1'b0};
    tbl[3] = '{8'hD0, 8'h78, 1'b0, 1'b0};
    tbl[4] = '{8'hD0, 8'hF0, 1'b0, 1'b0};
    tbl[5] = '{8'h32, 8'hF0, 1'b0, 1'b0};
    tbl[6] = '{8'h42, 8'hE0, 1'b0, 1'b1};
    tbl[7] = '{8'h52, 8'hF0, 1'b0, 1'b1};
    tbl[8] = '{8'h82, 8'h00, 1'b1, 1'b1};

    // Vector table from address 0, zero-wait memory
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = tbl[i].ins;
    do_reset();
    check("reset_state", {12'd0, pc, acc, zf, cf, halted, retire, imem_req, imem_addr},
          {12'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    cyc0 = cyc;
    r0   = rcnt;
    for (int i = 0; i < 9; i++) begin
      wait_retire(ok);
      @(negedge clk);
      check($sformatf("tbl[%0d]", i), {14'd0, pc, acc, zf, cf},
            {14'd0, 8'(i + 1), tbl[i].acc, tbl[i].zf, tbl[i].cf});
      if (i == 7) begin
        check("cycles_8_instr", 32'(cyc - cyc0), 32'd16);
        check("retires_8_instr", 32'(rcnt - r0), 32'd8);
      end
    end

    // Conditional branch targets
    branch_case("jz_taken", 8'h10, 8'hB2, 8'h14);
    branch_case("jz_not_taken", 8'h11, 8'hB2, 8'h12);
    branch_case("jz_self_loop", 8'h10, 8'hBF, 8'h11);

    // Fetch wait states at pc=0x05
    clear_mem();
    stall_addr = 8'h05;
    stall_left = 3;
    do_reset();
    run_instr(5);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("wait_hold[%0d]", c), {15'd0, imem_req, imem_addr, pc, retire},
            {15'd0, 1'b1, 8'h05, 8'h05, 1'b0});
      @(negedge clk);
    end
    check("wait_release", {23'd0, retire, pc}, {23'd0, 1'b1, 8'h06});

    // JR through a stored register, then HLT
    clear_mem();
    mem[0] = 8'h19; mem[1] = 8'h33; mem[2] = 8'h10; mem[3] = 8'h93; mem[9] = 8'hF0;
    do_reset();
    run_instr(4);
    check("jr_target", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h09});
    run_instr(1);
    check("halt_entry", {22'd0, halted, imem_req, pc}, {22'd0, 1'b1, 1'b0, 8'h0A});
    bad = 1'b0;
    repeat (22) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h0A || retire !== 1'b0) bad = 1'b1;
    end
    check("halt_frozen", {31'd0, bad}, 32'd0);

    // Reset out of HALT clears the register file
    mem[0] = 8'h23;
    do_reset();
    check("clb_from_halt", {12'd0, pc, acc, zf, cf, halted, retire, imem_req, imem_addr},
          {12'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    run_instr(1);
    check("ldr_after_clb", {23'd0, acc, zf}, {23'd0, 8'h00, 1'b1});

    // Reset mid-wait, coinciding with an ack that must be ignored
    clear_mem();
    mem[0] = 8'h15;
    stall_addr = 8'h02;
    stall_left = 2;
    do_reset();
    run_instr(2);
    @(negedge clk);
    @(negedge clk);
    CLB = 1'b1;
    @(negedge clk);
    CLB = 1'b0;
    check("clb_mid_wait", {12'd0, pc, acc, zf, cf, halted, retire, imem_req, imem_addr},
          {12'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});

    // Random programs with random wait states against the model
    stall_left = 0;
    rnd_mode   = 1'b1;
    for (int trial = 0; trial < 6; trial++) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      do_reset();
      model_reset();
      for (int k = 0; k < 60; k++) begin
        wait_retire(ok);
        if (!ok) break;
        model_step();
        @(negedge clk);
        check($sformatf("rnd[%0d][%0d]", trial, k), {13'd0, pc, acc, zf, cf, halted},
              {13'd0, 8'(m_pc), 8'(m_acc), m_zf, m_cf, m_halt});
        if (m_halt) break;
      end
    end
    rnd_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/acc_core_mc.md
Name: acc_core_mc

Overview:
- Parametrised multi-cycle accumulator CPU core; next generation of the single-cycle accumulator core.
- Adds generic data/PC/register-file widths, an instruction-memory request/acknowledge handshake with wait states, relative and conditional branches, carry/zero flags, and a HALT state.
- Sits between the instruction memory (ROM or cached memory) and the debug/trace logic.

Parameters:
- DATA_W, default 8: accumulator, register and ALU width.
- PC_W, default 8: program counter and instruction address width.
- NREG, default 16: number of registers. Register address RA_W = clog2(NREG).
- OPND_W, default 4: operand field width. Must satisfy OPND_W >= RA_W. Instruction width INS_W = 4 + OPND_W.
- RESET_PC, default 0: PC value after reset.

Ports:
- clk  in  1  clock.
- CLB  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (equals pc).
- imem_ack  in  1  imem_data valid this cycle.
- imem_data  in  INS_W  instruction: {op[3:0], opnd[OPND_W-1:0]}.
- pc  out  PC_W  current PC.
- acc  out  DATA_W  accumulator.
- zf  out  1  zero flag.
- cf  out  1  carry flag.
- retire  out  1  one-cycle pulse per executed instruction.
- halted  out  1  core is in HALT.

Behaviour:
- Reset: all state changes on the rising clk edge; CLB sampled there.
  - pc=RESET_PC; acc, IR, zf, cf and every register = 0.
  - state=FETCH; retire=0; halted=0.
  - CLB overrides everything, mid-fetch or in HALT. A pending imem_ack in that cycle is ignored.
- FSM states: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc. Both held stable until imem_ack.
  - No ack: no state change.
  - On ack: IR<=imem_data, pc<=pc+1 (mod 2^PC_W), go to EXEC.
- EXEC:
  - One cycle; retire=1; performs the operation, then goes to FETCH.
  - HLT goes to HALT instead (retire still pulses). imem_req=0.
- HALT: imem_req=0, halted=1; exits only through CLB.
- Throughput: 2 cycles per instruction with ack in the request cycle, plus 1 per wait cycle.
- Operand decoding:
  - R = reg[opnd[RA_W-1:0]].
  - imm = zero-extend(opnd) to DATA_W.
  - off = sign-extend(opnd) to PC_W.
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc<=imm.
  - 2 LDR: acc<=R.
  - 3 STR: R<=acc.
  - 4 ADD: {cf,acc}<=acc+R.
  - 5 SUB: acc<=acc-R; cf<=borrow (acc<R unsigned).
  - 6 AND, 7 OR, 8 XOR: acc<=acc op R.
  - 9 JR: pc<=R[PC_W-1:0], zero-extended if DATA_W<PC_W.
  - A BRA: pc<=pc+off.
  - B JZ: pc<=pc+off if zf.
  - C JC: pc<=pc+off if cf.
  - D SHL: cf<=acc[MSB], acc<=acc<<1.
  - E SHR: cf<=acc[0], acc<=acc>>1.
  - F HLT.
- Branch targets use the already-incremented pc and wrap modulo 2^PC_W. An offset of -1 loops on the branch itself.
- Flags:
  - zf updates on every acc write (ops 1,2,4-8,D,E) to (new acc==0).
  - cf updates only on 4,5,D,E.
  - STR, branches and NOP leave both flags unchanged.
- Unused operand bits above RA_W are ignored for register ops.
- All outputs are registered state or direct decodes of state. No combinational path from imem_* to any output.

Decomposition:
- Package acc_core_pkg holds:
  - opcode localparams OP_NOP..OP_HLT;
  - state encoding ST_FETCH/ST_EXEC/ST_HALT;
  - ALU-function constants.
- Sub-module acc_core_alu is combinational. Inputs: a, b, func, cin. Outputs: result, cout, zero. Parametrised by DATA_W.
- Register file and FSM stay in acc_core_mc.

Test Plan:
- Reset then program LDI 15, SHL x4, STR R2, ADD R2, zero-wait memory:
  - after SHLs acc=0xF0, cf=0;
  - after ADD acc=0xE0, cf=1, zf=0;
  - 8 instructions take 16 cycles, 8 retire pulses.
- Continue with SUB R2: acc=0xF0, cf=1. Then XOR R2: acc=0x00, zf=1, cf unchanged =1.
- LDI 0 at address 0x10, JZ +2 (opnd=0x2), then NOP ×2: next fetch address 0x14. Same with LDI 1: next fetch 0x12. JZ with opnd=0xF: next fetch is the JZ address itself.
- imem_ack withheld 3 cycles during FETCH at pc=0x05: imem_req=1 and imem_addr=0x05 held 4 cycles, pc stays 0x05, no retire until the ack arrives.
- LDI 9, STR R3, LDI 0, JR R3: next imem_addr=0x09. Then HLT: halted=1, imem_req=0 for 20+ cycles, pc frozen.
- CLB asserted for 1 cycle while in HALT and while mid-wait in FETCH: next cycle pc=RESET_PC, acc=0, flags 0, halted=0, imem_req=1, imem_addr=RESET_PC. A prior STR value reads back as 0 through LDR.
